alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 147 ++++++++++++++
 tb/tb_alu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 2-bit operand, 16-operation ALU with a registered 7-bit result.
//
// A, B and ALU_Sel are sampled on every rising clk edge; ALU_Out and CarryOut
// show the result of that operation from the same edge onward (1-cycle
// latency, no handshake, a new operation may be issued every cycle).
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset (clears both outputs)
//   A         in   2  operand A, unsigned
//   B         in   2  operand B, unsigned
//   ALU_Sel   in   4  operation select (all 16 codes defined)
//   ALU_Out   out  7  registered result
//   CarryOut  out  1  registered carry / borrow / divide-error flag
//
// Configuration macro: ALU_MULDIV_EN
//   defined   -> 0x2 MUL and 0x3 DIV are implemented
//   undefined -> 0x2 and 0x3 return zero and no multiplier/divider is built
// ---------------------------------------------------------------------------
module alu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic [3:0] ALU_Sel,
    output logic [6:0] ALU_Out,
    output logic       CarryOut
);

    localparam int unsigned OPW  = 2;
    localparam int unsigned SELW = 4;
    localparam int unsigned RESW = 7;

    // Operation codes
    localparam logic [SELW-1:0] OP_ADD  = 4'h0;
    localparam logic [SELW-1:0] OP_SUB  = 4'h1;
    localparam logic [SELW-1:0] OP_MUL  = 4'h2;
    localparam logic [SELW-1:0] OP_DIV  = 4'h3;
    localparam logic [SELW-1:0] OP_SHL  = 4'h4;
    localparam logic [SELW-1:0] OP_SHR  = 4'h5;
    localparam logic [SELW-1:0] OP_ROL  = 4'h6;
    localparam logic [SELW-1:0] OP_ROR  = 4'h7;
    localparam logic [SELW-1:0] OP_AND  = 4'h8;
    localparam logic [SELW-1:0] OP_OR   = 4'h9;
    localparam logic [SELW-1:0] OP_XOR  = 4'hA;
    localparam logic [SELW-1:0] OP_NOR  = 4'hB;
    localparam logic [SELW-1:0] OP_NAND = 4'hC;
    localparam logic [SELW-1:0] OP_XNOR = 4'hD;
    localparam logic [SELW-1:0] OP_GT   = 4'hE;
    localparam logic [SELW-1:0] OP_EQ   = 4'hF;

    logic [RESW-1:0] r_out;
    logic            r_carry;

    logic [RESW-1:0] w_res;
    logic            w_carry;
    logic [OPW:0]    w_sum;     // 3-bit sum; bit 2 is the add carry
    logic [RESW-1:0] w_diff;    // sign-extended difference

`ifdef ALU_MULDIV_EN
    logic [2*OPW-1:0] w_prod;   // 0..9
    logic [OPW-1:0]   w_quot;   // 0..3
    logic             w_div0;
`endif

    // Shared arithmetic terms, widened before the operator so nothing truncates
    always_comb begin
        w_sum  = (OPW+1)'(A) + (OPW+1)'(B);
        w_diff = RESW'(A) - RESW'(B);
    end

`ifdef ALU_MULDIV_EN
    // Multiplier and divider; divide by zero yields quotient 0 plus error flag
    always_comb begin
        w_prod = (2*OPW)'(A) * (2*OPW)'(B);
        w_div0 = (B == '0);
        w_quot = w_div0 ? '0 : (A / B);
    end
`endif

    // Result and flag selection
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        case (ALU_Sel)
            OP_ADD: begin
                w_res   = RESW'(w_sum);
                w_carry = w_sum[OPW];
            end
            OP_SUB: begin
                w_res   = w_diff;
                w_carry = (A < B);
            end
`ifdef ALU_MULDIV_EN
            OP_MUL: w_res = RESW'(w_prod);
            OP_DIV: begin
                w_res   = RESW'(w_quot);
                w_carry = w_div0;
            end
`else
            // Left at the zero defaults when mul/div are not built
            OP_MUL: w_res = '0;
            OP_DIV: w_res = '0;
`endif
            OP_SHL: begin
                w_res   = RESW'({A, 1'b0});
                w_carry = A[1];
            end
            OP_SHR: begin
                w_res   = RESW'(A[1]);
                w_carry = A[0];
            end
            // A one-place rotate of a 2-bit value is a bit swap in either direction
            OP_ROL:  w_res = RESW'({A[0], A[1]});
            OP_ROR:  w_res = RESW'({A[0], A[1]});
            OP_AND:  w_res = RESW'(A & B);
            OP_OR:   w_res = RESW'(A | B);
            OP_XOR:  w_res = RESW'(A ^ B);
            // Inversion confined to the 2 operand bits; upper bits stay zero
            OP_NOR:  w_res = RESW'(OPW'(~(A | B)));
            OP_NAND: w_res = RESW'(OPW'(~(A & B)));
            OP_XNOR: w_res = RESW'(OPW'(~(A ^ B)));
            OP_GT:   w_res = RESW'(A > B);
            OP_EQ:   w_res = RESW'(A == B);
            default: begin
                w_res   = '0;
                w_carry = 1'b0;
            end
        endcase
    end

    // Output registers -- the only state in the block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_out   <= w_res;
            r_carry <= w_carry;
        end
    end

    assign ALU_Out  = r_out;
    assign CarryOut = r_carry;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu.
// Vector table plus hand-written reset sequences and a random sweep checked
// against an arithmetic reference model; expectations flow through a queue.
// ---------------------------------------------------------------------------
module tb_alu;

`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] sel;
    logic [6:0] out;
    logic       cout;

    always #5 clk = ~clk;

    alu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (a),
        .B        (b),
        .ALU_Sel  (sel),
        .ALU_Out  (out),
        .CarryOut (cout)
    );

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] sel;
        logic [6:0] out;
        logic       c;
    } vec_t;

    typedef struct {
        logic [6:0] out;
        logic       c;
        string      name;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string nm, input logic [6:0] ao, input logic ac,
                         input logic [6:0] eo, input logic ec);
        total++;
        if (ao !== eo || ac !== ec) begin
            bad++;
            $display("FAIL %s: got out=0x%02h c=%0b, want out=0x%02h c=%0b",
                     nm, ao, ac, eo, ec);
        end
    endtask

    // Independent reference written in integer arithmetic
    function automatic exp_t model(input int ia, input int ib, input int op);
        exp_t e;
        int   r;
        int   c;
        r = 0;
        c = 0;
        case (op)
            0:  begin r = ia + ib; c = (r >= 4) ? 1 : 0; end
            1:  begin r = (ia - ib) & 127; c = (ia < ib) ? 1 : 0; end
            2:  r = MD ? ia * ib : 0;
            3:  begin
                    if (ib == 0) begin r = 0; c = MD ? 1 : 0; end
                    else r = MD ? ia / ib : 0;
                end
            4:  begin r = ia * 2; c = (ia >= 2) ? 1 : 0; end
            5:  begin r = ia / 2; c = ia % 2; end
            6, 7: r = (ia % 2) * 2 + ia / 2;
            8:  r = ia & ib;
            9:  r = ia | ib;
            10: r = ia ^ ib;
            11: r = 3 - (ia | ib);
            12: r = 3 - (ia & ib);
            13: r = 3 - (ia ^ ib);
            14: r = (ia > ib) ? 1 : 0;
            default: r = (ia == ib) ? 1 : 0;
        endcase
        e.out  = 7'(r);
        e.c    = 1'(c);
        e.name = "model";
        return e;
    endfunction

    // Drive one operation, queue its expectation, check it after the edge
    task automatic apply(input logic [1:0] ia, input logic [1:0] ib, input logic [3:0] is,
                         input logic [6:0] eo, input logic ec, input string nm);
        exp_t e;
        @(negedge clk);
        a   = ia;
        b   = ib;
        sel = is;
        e.out  = eo;
        e.c    = ec;
        e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            check(e.name, out, cout, e.out, e.c);
        end
    endtask

    initial begin
        exp_t m;

        // Sweep A=2,B=2 over all selects
        tbl.push_back('{2'd2, 2'd2, 4'h0, 7'd4, 1'b1});
        tbl.push_back('{2'd2, 2'd2, 4'h1, 7'd0, 1'b0});
        tbl.push_back('{2'd2, 2'd2, 4'h2, MD ? 7'd4 : 7'd0, 1'b0});
        tbl.push_back('{2'd2, 2'd2, 4'h3, MD ? 7'd1 : 7'd0, 1'b0});
        tbl.push_back('{2'd2, 2'd2, 4'h4, 7'd4, 1'b1});
        tbl.push_back('{2'd2, 2'd2, 4'h5, 7'd1, 1'b0});
        tbl.push_back('{2'd2, 2'd2, 4'h6, 7'd1, 1'b0});
        tbl.push_back('{2'd2, 2'd2, 4'h7, 7'd1, 1'b0});
        tbl.push_back('{2'd2, 2'd2, 4'h8, 7'd2, 1'b0});
        tbl.push_back('{2'd2, 2'd2, 4'h9, 7'd2, 1'b0});
        tbl.push_back('{2'd2, 2'd2, 4'hA, 7'd0, 1'b0});
        tbl.push_back('{2'd2, 2'd2, 4'hB, 7'd1, 1'b0});
        tbl.push_back('{2'd2, 2'd2, 4'hC, 7'd1, 1'b0});
        tbl.push_back('{2'd2, 2'd2, 4'hD, 7'd3, 1'b0});
        tbl.push_back('{2'd2, 2'd2, 4'hE, 7'd0, 1'b0});
        tbl.push_back('{2'd2, 2'd2, 4'hF, 7'd1, 1'b0});
        // Wrap 0xF -> 0x0 and assorted corners
        tbl.push_back('{2'd3, 2'd3, 4'h0, 7'd6, 1'b1});
        tbl.push_back('{2'd1, 2'd3, 4'h1, 7'h7E, 1'b1});
        tbl.push_back('{2'd1, 2'd3, 4'hE, 7'd0, 1'b0});
        tbl.push_back('{2'd0, 2'd1, 4'h1, 7'h7F, 1'b1});
        tbl.push_back('{2'd3, 2'd1, 4'h1, 7'd2, 1'b0});
        tbl.push_back('{2'd3, 2'd0, 4'h3, 7'd0, MD});
        tbl.push_back('{2'd3, 2'd3, 4'h2, MD ? 7'd9 : 7'd0, 1'b0});
        tbl.push_back('{2'd3, 2'd2, 4'h3, MD ? 7'd1 : 7'd0, 1'b0});
        tbl.push_back('{2'd3, 2'd0, 4'h4, 7'd6, 1'b1});
        tbl.push_back('{2'd1, 2'd0, 4'h5, 7'd0, 1'b1});
        tbl.push_back('{2'd1, 2'd0, 4'h6, 7'd2, 1'b0});
        tbl.push_back('{2'd2, 2'd0, 4'h7, 7'd1, 1'b0});
        tbl.push_back('{2'd0, 2'd0, 4'hB, 7'd3, 1'b0});
        tbl.push_back('{2'd3, 2'd3, 4'hC, 7'd0, 1'b0});
        tbl.push_back('{2'd1, 2'd2, 4'hD, 7'd0, 1'b0});
        tbl.push_back('{2'd3, 2'd2, 4'hE, 7'd1, 1'b0});
        tbl.push_back('{2'd1, 2'd2, 4'hF, 7'd0, 1'b0});

        // Reset held from time 0 with live inputs
        rst_n = 1'b0;
        a     = 2'd3;
        b     = 2'd3;
        sel   = 4'h0;
        #1;
        check("reset_t0", out, cout, 7'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", out, cout, 7'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release_first", out, cout, 7'd6, 1'b1);

        foreach (tbl[i])
            apply(tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].out, tbl[i].c,
                  $sformatf("vec%0d_sel%0h", i, tbl[i].sel));

        // Mid-stream asynchronous reset between edges
        apply(2'd3, 2'd3, 4'h0, 7'd6, 1'b1, "pre_reset_add");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", out, cout, 7'd0, 1'b0);
        sb.delete();
        @(negedge clk);
        a   = 2'd2;
        b   = 2'd2;
        sel = 4'h4;
        @(posedge clk);
        #1;
        check("reset_hold_edge", out, cout, 7'd0, 1'b0);
        @(negedge clk);
        a     = 2'd1;
        b     = 2'd3;
        sel   = 4'h1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_first", out, cout, 7'h7E, 1'b1);

        // Random back-to-back operations against the model
        for (int k = 0; k < 200; k++) begin
            logic [1:0] ra;
            logic [1:0] rb;
            logic [3:0] rs;
            ra = 2'($urandom_range(3, 0));
            rb = 2'($urandom_range(3, 0));
            rs = 4'($urandom_range(15, 0));
            m  = model(int'(ra), int'(rb), int'(rs));
            apply(ra, rb, rs, m.out, m.c,
                  $sformatf("rand%0d_a%0d_b%0d_sel%0h", k, ra, rb, rs));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
